// File: rtl/dds_core.sv
// dds_core: loads one waveform period into RAM, then plays it back through a
// phase accumulator stepped by the tuning code.
module dds_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int STEP   = 2**(ACC_W-ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_control,
  input  logic [2:0]        dds_control,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              full_ram,
  output logic [DATA_W-1:0] dds_out,
  output logic              dds_valid
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  inc;
  logic              wr_en;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign inc   = ACC_W'(dds_control) * ACC_W'(STEP);
  assign wr_en = !reset && state_q == LOAD && wr_valid && !full_ram;
  // RAM is never cleared; full_ram alone gates playback of stale contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      acc_q     <= '0;
      full_ram  <= 1'b0;
      dds_out   <= '0;
      dds_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (we_control) begin
            state_q   <= LOAD;
            wr_addr_q <= '0;
            full_ram  <= 1'b0;
          end else if (dds_control != 3'd0 && full_ram) begin
            state_q <= RUN;
            acc_q   <= '0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (&wr_addr_q) full_ram <= 1'b1;
          end
          if (!we_control) state_q <= IDLE;
        end
        RUN: begin
          if (we_control) begin
            state_q   <= LOAD;
            wr_addr_q <= '0;
            full_ram  <= 1'b0;
            acc_q     <= '0;
            dds_out   <= '0;
            dds_valid <= 1'b0;
          end else if (dds_control == 3'd0) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            dds_out   <= '0;
            dds_valid <= 1'b0;
          end else begin
            dds_out   <= mem[acc_q[ACC_W-1 -: ADDR_W]];
            dds_valid <= 1'b1;
            acc_q     <= acc_q + inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
